// File: rtl/ir_fetch_unit.sv
// Instruction fetch: reads 4-byte instructions out of the IR regfile
// and presents them to execute over a valid/ready handshake.
module ir_fetch_unit #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_OP    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_done,
    input  logic                  start,
    output logic                  ir_regfile_ren,
    output logic [ADDR_WIDTH-1:0] ir_regfile_raddr,
    input  logic [DATA_WIDTH-1:0] ir_regfile_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic [DATA_WIDTH-1:0] o_p0,
    output logic [DATA_WIDTH-1:0] o_p1,
    output logic [DATA_WIDTH-1:0] o_p2,
    output logic [ADDR_WIDTH-1:0] o_pc,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  o_busy,
    output logic                  o_halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_IR,
        S_FETCH_P0,
        S_FETCH_P1,
        S_FETCH_P2,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_p0;
    logic [DATA_WIDTH-1:0] r_p1;
    logic [DATA_WIDTH-1:0] r_p2;
    logic [ADDR_WIDTH-1:0] r_opc;
    logic                  r_halted;

    logic                  w_ren;
    logic [ADDR_WIDTH-1:0] w_off;

    // Each fetch state issues the byte whose data is captured one state later.
    always_comb begin
        w_ren = 1'b0;
        w_off = '0;
        unique case (r_state)
            S_FETCH_IR: begin
                w_ren = 1'b1;
                w_off = ADDR_WIDTH'(0);
            end
            S_FETCH_P0: begin
                w_ren = 1'b1;
                w_off = ADDR_WIDTH'(1);
            end
            S_FETCH_P1: begin
                w_ren = 1'b1;
                w_off = ADDR_WIDTH'(2);
            end
            S_FETCH_P2: begin
                w_ren = 1'b1;
                w_off = ADDR_WIDTH'(3);
            end
            default: ;
        endcase
    end

    assign ir_regfile_ren   = w_ren;
    assign ir_regfile_raddr = w_ren ? r_pc + w_off : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= PC_RESET;
            r_valid  <= 1'b0;
            r_ir     <= '0;
            r_p0     <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_opc    <= '0;
            r_halted <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start && load_done) begin
                r_pc     <= PC_RESET;
                r_halted <= 1'b0;
                r_state  <= S_FETCH_IR;
            end
        end else if (jump_en) begin
            // Redirect beats a same-cycle handshake; partial fields are dropped.
            r_pc    <= jump_addr;
            r_valid <= 1'b0;
            r_state <= S_FETCH_IR;
        end else begin
            unique case (r_state)
                S_FETCH_IR: begin
                    r_state <= S_FETCH_P0;
                end
                S_FETCH_P0: begin
                    r_ir    <= ir_regfile_rdata;
                    r_state <= S_FETCH_P1;
                end
                S_FETCH_P1: begin
                    r_p0    <= ir_regfile_rdata;
                    r_state <= S_FETCH_P2;
                end
                S_FETCH_P2: begin
                    r_p1    <= ir_regfile_rdata;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_p2    <= ir_regfile_rdata;
                    r_opc   <= r_pc;
                    r_valid <= 1'b1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_valid && i_ready) begin
                        r_valid <= 1'b0;
                        if (r_ir == HALT_OP) begin
                            r_halted <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_pc    <= r_pc + ADDR_WIDTH'(4);
                            r_state <= S_FETCH_IR;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_valid  = r_valid;
    assign o_ir     = r_ir;
    assign o_p0     = r_p0;
    assign o_p1     = r_p1;
    assign o_p2     = r_p2;
    assign o_pc     = r_opc;
    assign o_busy   = (r_state != S_IDLE);
    assign o_halted = r_halted;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: regfile memory, timing-level reference
// model with a per-cycle compare, directed cases and random traffic.
module tb_ir_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       load_done;
    logic       start;
    logic       ren;
    logic [7:0] raddr;
    logic [7:0] rdata;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_ir;
    logic [7:0] o_p0;
    logic [7:0] o_p1;
    logic [7:0] o_p2;
    logic [7:0] o_pc;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       o_busy;
    logic       o_halted;

    int n_chk;
    int n_fail;

    logic [7:0] mem [256];

    ir_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_done        (load_done),
        .start            (start),
        .ir_regfile_ren   (ren),
        .ir_regfile_raddr (raddr),
        .ir_regfile_rdata (rdata),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_ir             (o_ir),
        .o_p0             (o_p0),
        .o_p1             (o_p1),
        .o_p2             (o_p2),
        .o_pc             (o_pc),
        .jump_en          (jump_en),
        .jump_addr        (jump_addr),
        .o_busy           (o_busy),
        .o_halted         (o_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Model: m_t counts cycles since the current instruction's fetch began.
    // Bytes are read at m_t = 0..3, the instruction is offered from m_t = 5.
    logic       m_busy;
    logic       m_halted;
    logic [7:0] m_pc;
    int         m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_halted <= 1'b0;
            m_pc     <= 8'h00;
            m_t      <= 0;
        end else if (!m_busy) begin
            if (start && load_done) begin
                m_busy   <= 1'b1;
                m_halted <= 1'b0;
                m_pc     <= 8'h00;
                m_t      <= 0;
            end
        end else if (jump_en) begin
            m_pc <= jump_addr;
            m_t  <= 0;
        end else if (m_t == 5) begin
            if (i_ready) begin
                if (mem[m_pc] == 8'hFF) begin
                    m_busy   <= 1'b0;
                    m_halted <= 1'b1;
                end else begin
                    m_pc <= m_pc + 8'd4;
                    m_t  <= 0;
                end
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic       e_ren;
    logic       e_valid;
    logic [7:0] e_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            e_ren   = m_busy && (m_t < 4);
            e_valid = m_busy && (m_t == 5);
            e_addr  = e_ren ? m_pc + 8'(m_t) : 8'h00;
            chk("busy", o_busy, m_busy);
            chk("halted", o_halted, m_halted);
            chk("ren", ren, e_ren);
            chk("raddr", raddr, e_addr);
            chk("valid", o_valid, e_valid);
            if (e_valid) begin
                chk("ir", o_ir, mem[m_pc]);
                chk("p0", o_p0, mem[8'(m_pc + 8'd1)]);
                chk("p1", o_p1, mem[8'(m_pc + 8'd2)]);
                chk("p2", o_p2, mem[8'(m_pc + 8'd3)]);
                chk("pc", o_pc, m_pc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            start   = 1'b0;
            jump_en = 1'b0;
            if (o_valid) break;
        end
        chk("valid_seen", o_valid, 1);
    endtask

    int k;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        load_done = 1'b0;
        start     = 1'b0;
        i_ready   = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0]     = 8'h10;
        mem[1]     = 8'h21;
        mem[2]     = 8'h32;
        mem[3]     = 8'h43;
        mem[4]     = 8'h01;
        mem[8]     = 8'hFF;
        mem[8'h20] = 8'hFF;
        mem[8'hFE] = 8'h77;
        mem[8'hFF] = 8'h88;
        repeat (3) step();
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_ren", ren, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_ir", o_ir, 0);
        chk("rst_pc", o_pc, 0);
        rst_n = 1'b1;

        // start without load_done
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("noload_busy", o_busy, 0);
        chk("noload_ren", ren, 0);

        // basic fetch with a 10-cycle stall
        load_done = 1'b1;
        start     = 1'b1;
        wait_valid(k);
        chk("latency", k, 6);
        chk("b_ir", o_ir, 8'h10);
        chk("b_p0", o_p0, 8'h21);
        chk("b_p1", o_p1, 8'h32);
        chk("b_p2", o_p2, 8'h43);
        chk("b_pc", o_pc, 8'h00);
        repeat (10) step();
        chk("stall_valid", o_valid, 1);
        chk("stall_ren", ren, 0);
        chk("stall_p2", o_p2, 8'h43);
        i_ready = 1'b1;
        step();
        chk("next_raddr", raddr, 8'h04);
        chk("next_ren", ren, 1);
        wait_valid(k);
        chk("hs_to_valid", k, 5);
        chk("pc4", o_pc, 8'h04);
        wait_valid(k);
        chk("period", k, 6);
        chk("pc8", o_pc, 8'h08);
        chk("halt_op", o_ir, 8'hFF);
        step();
        chk("halt_set", o_halted, 1);
        chk("halt_busy", o_busy, 0);
        repeat (3) step();
        chk("halt_ren", ren, 0);

        // restart, then jump during FETCH_P1
        start   = 1'b1;
        i_ready = 1'b0;
        step();
        start = 1'b0;
        chk("restart_halted", o_halted, 0);
        chk("restart_raddr", raddr, 8'h00);
        chk("restart_ren", ren, 1);
        step();
        step();
        chk("p1_raddr", raddr, 8'h02);
        jump_en   = 1'b1;
        jump_addr = 8'h20;
        step();
        jump_en = 1'b0;
        chk("jump_raddr", raddr, 8'h20);
        wait_valid(k);
        chk("jump_lat", k, 5);
        chk("jump_pc", o_pc, 8'h20);
        chk("jump_ir", o_ir, 8'hFF);

        // jump and ready together on a halt opcode
        jump_en   = 1'b1;
        jump_addr = 8'hFE;
        i_ready   = 1'b1;
        step();
        jump_en = 1'b0;
        i_ready = 1'b0;
        chk("coll_raddr", raddr, 8'hFE);
        chk("coll_halted", o_halted, 0);
        chk("coll_busy", o_busy, 1);

        // wrap-around
        step();
        chk("wrap_ff", raddr, 8'hFF);
        step();
        chk("wrap_00", raddr, 8'h00);
        step();
        chk("wrap_01", raddr, 8'h01);
        wait_valid(k);
        chk("wrap_pc", o_pc, 8'hFE);
        chk("wrap_ir", o_ir, 8'h77);
        chk("wrap_p0", o_p0, 8'h88);
        chk("wrap_p1", o_p1, 8'h10);
        chk("wrap_p2", o_p2, 8'h21);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("wrap_next", raddr, 8'h02);

        // asynchronous reset during FETCH_P2
        step();
        step();
        step();
        chk("p2_raddr", raddr, 8'h05);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_busy", o_busy, 0);
        chk("ar_ren", ren, 0);
        chk("ar_raddr", raddr, 0);
        chk("ar_valid", o_valid, 0);
        chk("ar_ir", o_ir, 0);
        chk("ar_p0", o_p0, 0);
        chk("ar_pc", o_pc, 0);
        chk("ar_halted", o_halted, 0);
        step();
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            step();
            load_done = ($urandom_range(0, 7) != 0);
            start     = ($urandom_range(0, 5) == 0);
            i_ready   = $urandom_range(0, 1) == 1;
            jump_en   = ($urandom_range(0, 23) == 0);
            jump_addr = 8'($urandom);
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
